// File: rtl/gray_seq_pkg.sv
// rtl/gray_seq_pkg.sv - shared state encoding and counter width for gray_seq_ctrl
package gray_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/gray_enc.sv
// rtl/gray_enc.sv - combinational binary to Gray encoder
module gray_enc
  import gray_seq_pkg::*;
(
  input  logic [CNT_W-1:0] bin,
  output logic [CNT_W-1:0] gray
);

  // Adjacent binary values differ in exactly one Gray bit.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - button-driven Gray counter sequencer (optional GRAY_SEQ_DEBOUNCE_EN)
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_load,
  input  logic             dir,
  input  logic [CNT_W-1:0] sw,
  output logic [CNT_W-1:0] led,
  output logic             busy,
  output logic             wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
    $error("gray_seq_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
  end

  // Bit order in the synchronizer: {dir, load, stop, start}.
  logic [3:0] sync1, sync2;
  logic [2:0] btn_lvl, btn_lvl_q, btn_pulse;
  logic       start_p, stop_p, load_p, dir_s;

  // Two-flop synchronizer for all asynchronous inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {dir, btn_load, btn_stop, btn_start};
      sync2 <= sync1;
    end
  end

`ifdef GRAY_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    deb_lvl;

  // Debounced level follows the synchronized level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb_lvl[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb_lvl[i] <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign btn_lvl = deb_lvl;
`else
  assign btn_lvl = sync2[2:0];
`endif

  // Previous button level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_lvl_q <= '0;
    else     btn_lvl_q <= btn_lvl;
  end

  assign btn_pulse = btn_lvl & ~btn_lvl_q;
  assign start_p   = btn_pulse[0];
  assign stop_p    = btn_pulse[1];
  assign load_p    = btn_pulse[2];
  assign dir_s     = sync2[3];

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, led_next;
  logic [PW-1:0]    presc, presc_next;
  logic             tick, wrap_next;

  // State, counter, prescaler and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      presc <= '0;
      led   <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      presc <= presc_next;
      led   <= led_next;
      busy  <= (state_next == RUN);
      wrap  <= wrap_next;
    end
  end

  // Next-state, counter step, wrap detection and prescaler control.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wrap_next  = 1'b0;
    tick       = (state == RUN) && (presc == PRE_MAX);

    case (state)
      IDLE: begin
        if (!stop_p && start_p) state_next = RUN;
        if (load_p) cnt_next = sw;
      end
      RUN: begin
        if (stop_p) state_next = PAUSE;
        if (tick) begin
          if (dir_s) begin
            cnt_next  = cnt - CNT_W'(1);
            wrap_next = (cnt == '0);
          end else begin
            cnt_next  = cnt + CNT_W'(1);
            wrap_next = (cnt == '1);
          end
        end
      end
      PAUSE: begin
        if (stop_p) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (start_p) begin
          state_next = RUN;
        end
        // A load arriving with the clearing stop still lands, since PAUSE accepts loads.
        if (load_p) cnt_next = sw;
      end
      default: state_next = IDLE;
    endcase

    // Prescaler runs only while staying in RUN; any entry or exit restarts it at 0.
    if (state == RUN && state_next == RUN) presc_next = tick ? '0 : presc + PW'(1);
    else                                   presc_next = '0;
  end

  gray_enc u_gray_enc (
    .bin  (cnt_next),
    .gray (led_next)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - directed scoreboard bench for gray_seq_ctrl
module tb_gray_seq_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 8;
`ifdef GRAY_SEQ_DEBOUNCE_EN
  localparam int LAT  = 3 + DEB_CYCLES;
  localparam int HOLD = DEB_CYCLES + 2;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_load = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] sw = 4'b0000;
  logic [3:0] led;
  logic       busy;
  logic       wrap;

  typedef struct packed {
    logic [3:0] led;
    logic       busy;
    logic       wrap;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  gray_seq_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_load  (btn_load),
    .dir       (dir),
    .sw        (sw),
    .led       (led),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive buttons from just after an edge; returns 1 ns after the edge where the action lands.
  task automatic press(input logic s, input logic p, input logic l);
    btn_start = s;
    btn_stop  = p;
    btn_load  = l;
    repeat (HOLD) @(posedge clk);
    #1;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_load  = 1'b0;
    repeat (LAT - HOLD) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] l, input logic b, input logic w);
    exp_t e;
    e.led  = l;
    e.busy = b;
    e.wrap = w;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string tag;
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("FAIL sb_underflow got %0d entries want >0", sb.size());
    end
    if (sb.size() == 0) return;
    e   = sb.pop_front();
    tag = tag_q.pop_front();
    tests++;
    assert (led === e.led) else begin
      fails++;
      $error("FAIL %s led got %b want %b", tag, led, e.led);
    end
    tests++;
    assert (busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy got %b want %b", tag, busy, e.busy);
    end
    tests++;
    assert (wrap === e.wrap) else begin
      fails++;
      $error("FAIL %s wrap got %b want %b", tag, wrap, e.wrap);
    end
  endtask

  // Wait (bounded) for the next led change, check its spacing, then check the popped expectation.
  task automatic wait_change(input string tag, input int gap);
    logic [3:0] prev;
    int n;
    prev = led;
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (led !== prev) break;
    end
    if (led === prev) n = 99;
    tests++;
    assert (n === gap) else begin
      fails++;
      $error("FAIL %s gap got %0d cycles want %0d", tag, n, gap);
    end
    check_out();
  endtask

  initial begin
    // Reset state
    step(3);
    expect_out("reset", 4'b0000, 1'b0, 1'b0);
    check_out();
    rst = 1'b0;
    step(2);

    // Up-count from 0
    dir = 1'b0;
    expect_out("up_start", 4'b0000, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    expect_out("up1", 4'b0001, 1'b1, 1'b0);
    expect_out("up2", 4'b0011, 1'b1, 1'b0);
    expect_out("up3", 4'b0010, 1'b1, 1'b0);
    expect_out("up4", 4'b0110, 1'b1, 1'b0);
    expect_out("up5", 4'b0111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) wait_change("up_step", 4);

    // Asynchronous reset mid-count, no clock edge in between
    step(2);
    #3;
    rst = 1'b1;
    #1;
    expect_out("rst_async", 4'b0000, 1'b0, 1'b0);
    check_out();
    step(2);
    rst = 1'b0;

    // Reset discards a start pulse already in the synchronizer
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    expect_out("rst_inflight", 4'b0000, 1'b0, 1'b0);
    check_out();

    // Load in IDLE, load ignored in RUN
    sw = 4'b1010;
    expect_out("load_idle", 4'b1111, 1'b0, 1'b0);
    press(0, 0, 1);
    check_out();
    expect_out("load_start", 4'b1111, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    sw = 4'b0000;
    expect_out("load_in_run", 4'b1111, 1'b1, 1'b0);
    press(0, 0, 1);
    check_out();
    expect_out("load_continue", 4'b1110, 1'b1, 1'b0);
    wait_change("load_continue", 1);
    expect_out("load_pause", 4'b1110, 1'b0, 1'b0);
    press(0, 1, 0);
    check_out();
    expect_out("load_clear", 4'b0000, 1'b0, 1'b0);
    press(0, 1, 0);
    check_out();

    // Wrap going up 15 -> 0
    sw = 4'b1111;
    expect_out("wrap_up_load", 4'b1000, 1'b0, 1'b0);
    press(0, 0, 1);
    check_out();
    expect_out("wrap_up_start", 4'b1000, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    expect_out("wrap_up", 4'b0000, 1'b1, 1'b1);
    wait_change("wrap_up", 4);
    expect_out("wrap_up_end", 4'b0000, 1'b1, 1'b0);
    step(1);
    check_out();
    press(0, 1, 0);
    expect_out("wrap_up_idle", 4'b0000, 1'b0, 1'b0);
    press(0, 1, 0);
    check_out();

    // Wrap going down 0 -> 15
    dir = 1'b1;
    sw = 4'b0000;
    press(0, 0, 1);
    expect_out("wrap_dn_start", 4'b0000, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    expect_out("wrap_dn", 4'b1000, 1'b1, 1'b1);
    wait_change("wrap_dn", 4);
    expect_out("wrap_dn_end", 4'b1000, 1'b1, 1'b0);
    step(1);
    check_out();
    press(0, 1, 0);
    expect_out("clear_no_wrap", 4'b0000, 1'b0, 1'b0);
    press(0, 1, 0);
    check_out();

    // Start+stop together in RUN, stop again, restart from 0
    dir = 1'b0;
    expect_out("ss_run", 4'b0000, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    expect_out("ss_step", 4'b0001, 1'b1, 1'b0);
    wait_change("ss_step", 4);
    expect_out("ss_pause", 4'b0001, 1'b0, 1'b0);
    press(1, 1, 0);
    check_out();
    expect_out("ss_hold", 4'b0001, 1'b0, 1'b0);
    step(8);
    check_out();
    expect_out("ss_idle", 4'b0000, 1'b0, 1'b0);
    press(0, 1, 0);
    check_out();
    expect_out("ss_restart", 4'b0000, 1'b1, 1'b0);
    press(1, 0, 0);
    check_out();
    expect_out("ss_count0", 4'b0001, 1'b1, 1'b0);
    wait_change("ss_count0", 4);
    press(0, 1, 0);
    press(0, 1, 0);
    step(2);

    // Short start glitch
    btn_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_start = 1'b0;
`ifdef GRAY_SEQ_DEBOUNCE_EN
    step(DEB_CYCLES + 6);
    expect_out("glitch_filtered", 4'b0000, 1'b0, 1'b0);
    check_out();
    btn_start = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    btn_start = 1'b0;
    for (int n = 0; n < 30 && busy !== 1'b1; n++) step(1);
    expect_out("long_press", 4'b0000, 1'b1, 1'b0);
    check_out();
`else
    expect_out("glitch_runs", 4'b0000, 1'b1, 1'b0);
    check_out();
`endif

    tests++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL sb_leftover got %0d entries want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
